// File: rtl/ram_bist.sv
`default_nettype none
// ============================================================================
// Module   : ram_bist
// Purpose  : Single-port RAM with built-in pattern write / read-back / compare
//            self-test sequencer reporting pass, error count, first bad address.
// Revision : 1.0 - initial release
// ============================================================================
module ram_bist #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              inject,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int              C_DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] C_ADDR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_LAST  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_mode;
    logic                r_inject;
    logic                w_ena;
    logic                w_wea;
    logic [DATA_W-1:0]   w_dina;
    logic [DATA_W-1:0]   r_douta;
    logic                w_cmp_vld;
    logic [ADDR_W-1:0]   w_cmp_addr;
    logic                w_mismatch;
    logic [DATA_W-1:0]   r_mem [C_DEPTH];

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W+ADDR_W-1:0] ext;
        logic [DATA_W-1:0]        chk;
        ext = {{DATA_W{1'b0}}, a};
        for (int i = 0; i < DATA_W; i++) begin
            chk[i] = ~i[0];
        end
        case (m)
            2'd0:    pattern = ext[DATA_W-1:0];
            2'd1:    pattern = ~ext[DATA_W-1:0];
            2'd2:    pattern = a[0] ? ~chk : chk;
            default: pattern = '1;
        endcase
    endfunction

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The read issued in the previous cycle always belongs to r_addr-1;
    // in LAST the counter has wrapped to 0 so this yields DEPTH-1.
    always_comb begin
        w_state_nxt = r_state;
        w_ena       = 1'b0;
        w_wea       = 1'b0;
        w_dina      = '0;
        w_cmp_vld   = 1'b0;
        w_cmp_addr  = r_addr - ADDR_W'(1);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_ena  = 1'b1;
                w_wea  = 1'b1;
                w_dina = pattern(r_mode, r_addr) ^
                         {{(DATA_W-1){1'b0}}, (r_inject && (r_addr == '0))};
                if (r_addr == C_ADDR_MAX) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_ena     = 1'b1;
                w_cmp_vld = (r_addr != '0);
                if (r_addr == C_ADDR_MAX) begin
                    w_state_nxt = S_LAST;
                end
            end
            default: begin
                w_cmp_vld   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_mismatch = w_cmp_vld && (r_douta != pattern(r_mode, w_cmp_addr));
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_addr         <= '0;
            r_mode         <= 2'd0;
            r_inject       <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            done <= (r_state == S_LAST);
            if (w_mismatch) begin
                err_cnt <= err_cnt + (ADDR_W+1)'(1);
                if (err_cnt == '0) begin
                    first_err_addr <= w_cmp_addr;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode         <= mode;
                        r_inject       <= inject;
                        r_addr         <= '0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                    end
                end
                S_WRITE, S_READ: begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
                default: begin
                    pass <= (err_cnt == '0) && !w_mismatch;
                end
            endcase
        end
    end

    // Inferred single-port RAM; contents intentionally survive reset.
    always_ff @(posedge clka) begin
        if (w_ena) begin
            if (w_wea) begin
                r_mem[r_addr] <= w_dina;
            end else begin
                r_douta <= r_mem[r_addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_bist
// Purpose  : Self-checking bench for ram_bist (default and 3x2 configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bist;

    localparam int DEPTH = 32;
    localparam int SDEPTH = 8;

    logic       clka = 1'b0;
    logic       rst, start, inject;
    logic [1:0] mode;
    logic       busy, done, pass;
    logic [5:0] err_cnt;
    logic [4:0] first_err_addr;

    logic       s_start, s_inject;
    logic [1:0] s_mode;
    logic       s_busy, s_done, s_pass;
    logic [3:0] s_err_cnt;
    logic [2:0] s_first;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clka = ~clka;

    ram_bist #(.DATA_W(8), .ADDR_W(5)) dut (
        .clka(clka), .rst(rst), .start(start), .mode(mode), .inject(inject),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr)
    );

    ram_bist #(.DATA_W(2), .ADDR_W(3)) dut_s (
        .clka(clka), .rst(rst), .start(s_start), .mode(s_mode), .inject(s_inject),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err_cnt),
        .first_err_addr(s_first)
    );

    typedef struct {
        int mode; int inj; int rep_at; int rep_mode;
        int exp_pass; int exp_err; int exp_first; int ram_addr; int ram_data;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference pattern from plain arithmetic on the address
    function automatic int model_pat(input int m, input int a, input int w);
        int mask = (1 << w) - 1;
        int chk  = 0;
        for (int i = 0; i < w; i += 2) chk += (1 << i);
        case (m)
            0:       return a & mask;
            1:       return (~a) & mask;
            2:       return ((a % 2) == 0) ? chk : (chk ^ mask);
            default: return mask;
        endcase
    endfunction

    function automatic int model_mem(input int m, input int inj, input int a, input int w);
        return model_pat(m, a, w) ^ (((inj != 0) && (a == 0)) ? 1 : 0);
    endfunction

    // Starts a run in the current cycle and returns in its done cycle.
    task automatic run_big(input int m, input int inj, input int rep_at, input int rep_mode,
                           output int lat, output int gaps);
        logic [31:0] mv, rv;
        mv = m; rv = rep_mode;
        mode = mv[1:0]; inject = (inj != 0); start = 1'b1;
        @(posedge clka); #1;
        start = 1'b0; lat = 1; gaps = 0;
        check("clear_err", int'(err_cnt), 0);
        check("clear_pass", int'(pass), 0);
        while (!done && lat < 200) begin
            if (!busy) gaps++;
            start = (lat == rep_at);
            if (lat == rep_at) begin
                mode = rv[1:0]; inject = ~inject;
            end
            @(posedge clka); #1;
            lat++;
        end
        start = 1'b0;
        check("busy_in_done", int'(busy), 0);
    endtask

    task automatic run_small(input int m, input int inj, output int lat);
        logic [31:0] mv;
        mv = m;
        s_mode = mv[1:0]; s_inject = (inj != 0); s_start = 1'b1;
        @(posedge clka); #1;
        s_start = 1'b0; lat = 1;
        while (!s_done && lat < 100) begin
            @(posedge clka); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, gaps, cnt, a, m, inj;

        tbl[0] = '{0, 0, -1, 0, 1, 0, 0, 5, 8'h05};
        tbl[1] = '{0, 1, -1, 0, 0, 1, 0, 0, 8'h01};
        tbl[2] = '{2, 0, -1, 0, 1, 0, 0, 3, 8'hAA};
        tbl[3] = '{1, 0, -1, 0, 1, 0, 0, 3, 8'hFC};
        tbl[4] = '{0, 0, 10, 3, 1, 0, 0, 5, 8'h05};
        tbl[5] = '{3, 1, -1, 0, 0, 1, 0, 0, 8'hFE};
        tbl[6] = '{2, 1, -1, 0, 0, 1, 0, 0, 8'h54};

        rst = 1'b1; start = 1'b0; mode = 2'd0; inject = 1'b0;
        s_start = 1'b0; s_mode = 2'd0; s_inject = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_first", int'(first_err_addr), 0);
        rst = 1'b1;
        @(posedge clka); #1;

        // Small configuration: wrapping data, 2*8+2 latency
        run_small(0, 0, lat);
        check("s_latency", lat, 2*SDEPTH+2);
        check("s_pass", int'(s_pass), 1);
        check("s_err", int'(s_err_cnt), 0);
        check("s_mem6", int'(dut_s.r_mem[6]), 2);
        for (int r = 0; r < 3; r++) begin
            m = $urandom_range(0, 3); inj = $urandom_range(0, 1);
            @(posedge clka); #1;
            run_small(m, inj, lat);
            check("s_latency", lat, 2*SDEPTH+2);
            check("s_pass", int'(s_pass), inj ? 0 : 1);
            check("s_err", int'(s_err_cnt), inj);
            check("s_first", int'(s_first), 0);
            a = $urandom_range(0, SDEPTH-1);
            check("s_mem", int'(dut_s.r_mem[a]), model_mem(m, inj, a, 2));
            check("s_mem0", int'(dut_s.r_mem[0]), model_mem(m, inj, 0, 2));
        end

        // Table runs, each started in the previous run's done cycle
        for (int i = 0; i < 7; i++) begin
            run_big(tbl[i].mode, tbl[i].inj, tbl[i].rep_at, tbl[i].rep_mode, lat, gaps);
            check("latency", lat, 2*DEPTH+2);
            check("busy_gaps", gaps, 0);
            check("pass", int'(pass), tbl[i].exp_pass);
            check("err_cnt", int'(err_cnt), tbl[i].exp_err);
            check("first_err", int'(first_err_addr), tbl[i].exp_first);
            check("ram_word", int'(dut.r_mem[tbl[i].ram_addr]), tbl[i].ram_data);
        end
        @(posedge clka); #1;
        check("done_width", int'(done), 0);
        check("hold_err", int'(err_cnt), 1);

        // Reset mid-WRITE
        mode = 2'd0; inject = 1'b0; start = 1'b1;
        @(posedge clka); #1;
        start = 1'b0; cnt = 1;
        while (cnt < 20) begin @(posedge clka); #1; cnt++; end
        rst = 1'b0; #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_err", int'(err_cnt), 0);
        repeat (5) @(posedge clka);
        #1 rst = 1'b1;
        cnt = 0;
        repeat (80) begin @(posedge clka); #1; if (done) cnt++; end
        check("no_done_after_rst", cnt, 0);
        run_big(0, 0, -1, 0, lat, gaps);
        check("post_rst_latency", lat, 2*DEPTH+2);
        check("post_rst_pass", int'(pass), 1);

        // Reset mid-READ after the injected error was counted
        @(posedge clka); #1;
        mode = 2'd1; inject = 1'b1; start = 1'b1;
        @(posedge clka); #1;
        start = 1'b0; cnt = 1;
        while (cnt < 40) begin @(posedge clka); #1; cnt++; end
        check("mid_read_err", int'(err_cnt), 1);
        rst = 1'b0; #1;
        check("arst_err2", int'(err_cnt), 0);
        check("arst_busy2", int'(busy), 0);
        @(posedge clka); #1 rst = 1'b1;
        @(posedge clka); #1;

        // Randomized runs against the reference model
        for (int r = 0; r < 8; r++) begin
            m = $urandom_range(0, 3); inj = $urandom_range(0, 1);
            run_big(m, inj, $urandom_range(1, 64), $urandom_range(0, 3), lat, gaps);
            check("rnd_latency", lat, 2*DEPTH+2);
            check("rnd_gaps", gaps, 0);
            check("rnd_pass", int'(pass), inj ? 0 : 1);
            check("rnd_err", int'(err_cnt), inj);
            check("rnd_first", int'(first_err_addr), 0);
            check("rnd_mem0", int'(dut.r_mem[0]), model_mem(m, inj, 0, 8));
            for (int k = 0; k < 4; k++) begin
                a = $urandom_range(0, DEPTH-1);
                check("rnd_mem", int'(dut.r_mem[a]), model_mem(m, inj, a, 8));
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clka); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_bist.md
# ram_bist

Parametrised single-port RAM self-test block: owns an inferred single-port synchronous RAM plus the sequencer that exercises it. On a start request it writes a selectable data pattern to every address, reads every address back, compares against the expected pattern, and reports pass/fail, error count and first failing address. It is the parametrised successor to the fixed 32x8 RAM read/write exerciser and sits alongside it as a standalone test top.

## Interface
Parameters:
- DATA_W, 8, RAM word width (>= 2)
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W words

Ports:
- clka  in  1  clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a test run; accepted only in IDLE
- mode  in  2  pattern select, sampled on accepted start
- inject  in  1  error injection, sampled on accepted start
- busy  out  1  test run in progress
- done  out  1  one-cycle pulse when results are valid
- pass  out  1  1 = last run had zero mismatches
- err_cnt  out  ADDR_W+1  mismatch count of last run
- first_err_addr  out  ADDR_W  address of first mismatch of last run; 0 if none

## Operation
- RAM: DEPTH x DATA_W, single port, ena/wea/addra/dina/douta, read latency 1 cycle, no output register, write-first behaviour irrelevant (no same-cycle read of a written address). Contents are not cleared by reset.
- Expected pattern P(a) for address a, by latched mode:
  - 0: a zero-extended or truncated to DATA_W (low bits)
  - 1: bitwise inverse of mode-0 value
  - 2: checkerboard, 0101... (LSB=1) when a[0]=0, 1010... when a[0]=1
  - 3: all ones
- inject latched 1: data written to address 0 has bit 0 flipped; expected value is unflipped, so exactly one mismatch results.
- FSM states: IDLE -> WRITE -> READ -> LAST -> IDLE.
  - IDLE: ena=0. On start=1: latch mode/inject, clear err_cnt, first_err_addr and pass, addr=0, go WRITE.
  - WRITE: ena=1, wea=1, dina=P(addr) (with injection at address 0); addr increments; after addr DEPTH-1 go READ with addr=0.
  - READ: ena=1, wea=0; addr increments; douta from previous read compared in the following cycle; after addr DEPTH-1 go LAST.
  - LAST: compare final word; go IDLE; done asserted next cycle.
- Compare: on mismatch, err_cnt increments (cannot overflow: max DEPTH fits ADDR_W+1 bits); on the first mismatch of the run, first_err_addr captures the address.
- pass = (err_cnt == 0), updated together with done.
- start while busy is ignored; mode/inject changes mid-run are ignored.

## Timing
- Reset values: busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, FSM=IDLE, RAM ena=0.
- start sampled high at edge k (in IDLE): busy=1 from cycle k+1.
- Writes: cycles k+1 .. k+DEPTH. Reads issued: k+DEPTH+1 .. k+2*DEPTH. LAST: k+2*DEPTH+1.
- done=1 for exactly cycle k+2*DEPTH+2, busy=0 in that cycle; pass, err_cnt, first_err_addr valid from that cycle and held until the next accepted start.
- DEPTH=32: start at cycle 0 -> done at cycle 66.
- start high during the done cycle is accepted (FSM is in IDLE); results clear on the following edge.
- Reset asserted mid-run: all outputs return to reset values immediately (async); no done pulse; RAM contents undefined; a new start after release runs a full test.

## Test plan
- Default params, mode 0, inject 0, start pulse at cycle 0 -> busy cycles 1..65, done at cycle 66, pass=1, err_cnt=0, first_err_addr=0; RAM address 5 holds 0x05.
- Default params, mode 0, inject 1 -> done at 66, pass=0, err_cnt=1, first_err_addr=0; RAM address 0 holds 0x01.
- Mode 2 run then mode 1 back-to-back, second start in the done cycle -> both pass; address 3 holds 0xAA after mode 2, 0xFC after mode 1; second done exactly 66 cycles after first.
- start re-pulsed at cycle 10 of a run, mode changed to 3 -> ignored; done still at cycle 66, pattern of original mode, pass=1.
- rst driven low at cycle 20 (mid-WRITE), released at 25 -> busy/done/err_cnt=0 at once, no done pulse; subsequent start completes with pass=1.
- ADDR_W=3, DATA_W=2, mode 0 -> written data wraps (address 6 holds 2'b10), done 18 cycles after start, pass=1, err_cnt width 4.
